// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// Splits each 32-bit access into two 16-bit halfword accesses.
package sram_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_LEN         = 32;
    localparam int unsigned HALF_W          = 16;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned DEF_SRAM_ADDR_W = 18;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

endpackage

// File: rtl/sram_addr_map.sv
// Byte address to SRAM halfword address translation.
// Out-of-window addresses wrap by truncation.
module sram_addr_map
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
    input  logic [31:0]            byte_addr,
    input  logic                   half,
    output logic [SRAM_ADDR_W-1:0] hw_addr
);

    logic [31:0] offset_s;
    logic        unused_s;

    // Word index is the offset divided by four; bit 0 selects the halfword.
    always_comb begin
        offset_s = byte_addr - BASE_ADDR;
        hw_addr  = {offset_s[SRAM_ADDR_W:2], half};
        unused_s = ^{offset_s[31:SRAM_ADDR_W+1], offset_s[1:0]};
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: runs each 32-bit load/store as two timed 16-bit
// SRAM accesses and holds ready low until the word is complete.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned LEN         = DEF_LEN,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [LEN-1:0]         alu_result,
    input  logic [LEN-1:0]         st_value,
    output logic [LEN-1:0]         read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [HALF_W-1:0]      sram_dq_out,
    input  logic [HALF_W-1:0]      sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam logic [CNT_W-1:0] LAST_CNT = 4'(WAIT_CYCLES - 32'd1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [HALF_W-1:0]      st_hi_q, st_hi_d;
    logic [LEN-1:0]         read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [HALF_W-1:0]      dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   we_n_q, we_n_d;
    logic [SRAM_ADDR_W-1:0] req_addr_s;
    logic                   req_s;
    logic                   cnt_last_s;

    sram_addr_map #(
        .BASE_ADDR   (BASE_ADDR),
        .SRAM_ADDR_W (SRAM_ADDR_W)
    ) u_addr_map (
        .byte_addr (alu_result),
        .half      (1'b0),
        .hw_addr   (req_addr_s)
    );

    // Next-state, registered SRAM strobes and combinational ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        st_hi_d     = st_hi_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;
        ready       = 1'b0;
        req_s       = mem_r_en | mem_w_en;
        cnt_last_s  = (cnt_q == LAST_CNT);

        case (state_q)
            ST_IDLE: begin
                ready   = ~req_s;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                if (req_s) begin
                    // A simultaneous read and write request is treated as a write.
                    state_d     = ST_LOW;
                    cnt_d       = 4'd0;
                    wr_d        = mem_w_en;
                    st_hi_d     = st_value[LEN-1:HALF_W];
                    sram_addr_d = req_addr_s;
                    we_n_d      = ~mem_w_en;
                    dq_oe_d     = mem_w_en;
                    if (mem_w_en) begin
                        dq_out_d = st_value[HALF_W-1:0];
                    end else begin
                        dq_out_d = dq_out_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (cnt_last_s) begin
                    state_d     = ST_HIGH;
                    cnt_d       = 4'd0;
                    sram_addr_d = {sram_addr_q[SRAM_ADDR_W-1:1], 1'b1};
                    if (wr_q) begin
                        dq_out_d = st_hi_q;
                    end else begin
                        read_data_d[HALF_W-1:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HIGH: begin
                if (cnt_last_s) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    we_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (wr_q) begin
                        read_data_d = read_data_q;
                    end else begin
                        read_data_d[LEN-1:HALF_W] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            st_hi_q     <= {HALF_W{1'b0}};
            read_data_q <= {LEN{1'b0}};
            sram_addr_q <= {SRAM_ADDR_W{1'b0}};
            dq_out_q    <= {HALF_W{1'b0}};
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            st_hi_q     <= st_hi_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: two instances (WAIT_CYCLES 2 and 1),
// a transaction-timeline model per instance, and behavioural SRAM arrays.
module tb_sram_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_r_en_s   [2];
    logic        mem_w_en_s   [2];
    logic [31:0] alu_result_s [2];
    logic [31:0] st_value_s   [2];
    logic [31:0] read_data_s  [2];
    logic        ready_s      [2];
    logic [17:0] sram_addr_s  [2];
    logic [15:0] sram_dq_out_s[2];
    logic [15:0] sram_dq_in_s [2] = '{16'h0, 16'h0};
    logic        sram_dq_oe_s [2];
    logic        sram_we_n_s  [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;
    int wait_m [2] = '{2, 1};

    always #5 clock = ~clock;

    sram_mem_ctrl #(.LEN(32), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024), .SRAM_ADDR_W(18)) dut0 (
        .clock(clock), .reset(reset), .mem_r_en(mem_r_en_s[0]), .mem_w_en(mem_w_en_s[0]),
        .alu_result(alu_result_s[0]), .st_value(st_value_s[0]), .read_data(read_data_s[0]),
        .ready(ready_s[0]), .sram_addr(sram_addr_s[0]), .sram_dq_out(sram_dq_out_s[0]),
        .sram_dq_in(sram_dq_in_s[0]), .sram_dq_oe(sram_dq_oe_s[0]), .sram_we_n(sram_we_n_s[0])
    );

    sram_mem_ctrl #(.LEN(32), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024), .SRAM_ADDR_W(18)) dut1 (
        .clock(clock), .reset(reset), .mem_r_en(mem_r_en_s[1]), .mem_w_en(mem_w_en_s[1]),
        .alu_result(alu_result_s[1]), .st_value(st_value_s[1]), .read_data(read_data_s[1]),
        .ready(ready_s[1]), .sram_addr(sram_addr_s[1]), .sram_dq_out(sram_dq_out_s[1]),
        .sram_dq_in(sram_dq_in_s[1]), .sram_dq_oe(sram_dq_oe_s[1]), .sram_we_n(sram_we_n_s[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural SRAM: one array per instance, keyed by instance and halfword.
    logic [15:0] sram_mem [int];
    logic [15:0] shadow   [int];

    function automatic int key(input int i, input logic [17:0] a);
        return i * 32'h0010_0000 + int'(a);
    endfunction

    function automatic logic [15:0] sram_rd(input int kk);
        return sram_mem.exists(kk) ? sram_mem[kk] : 16'h0000;
    endfunction

    function automatic logic [15:0] shadow_rd(input int kk);
        return shadow.exists(kk) ? shadow[kk] : 16'h0000;
    endfunction

    function automatic logic [17:0] hw_base(input logic [31:0] a);
        logic [31:0] word;
        word = (a - 32'd1024) >> 2;
        return {word[16:0], 1'b0};
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (sram_we_n_s[i] == 1'b0) sram_mem[key(i, sram_addr_s[i])] = sram_dq_out_s[i];
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) sram_dq_in_s[i] = sram_rd(key(i, sram_addr_s[i]));
    end

    // Transaction model: k is the cycle index inside a transaction (request cycle = 0).
    bit          busy_m    [2];
    int          k_m       [2];
    bit          wr_m      [2];
    logic [17:0] base_m    [2];
    logic [31:0] data_m    [2];
    logic [31:0] exp_rd_m  [2];
    logic [17:0] exp_addr_m[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy_m[i] = 1'b0; k_m[i] = 0; wr_m[i] = 1'b0; base_m[i] = 18'h0;
            data_m[i] = 32'h0; exp_rd_m[i] = 32'h0; exp_addr_m[i] = 18'h0;
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            int wc;
            wc = wait_m[i];
            if (busy_m[i] && wr_m[i] && k_m[i] >= 1 && k_m[i] <= 2 * wc) begin
                if (k_m[i] <= wc) shadow[key(i, base_m[i])] = data_m[i][15:0];
                else              shadow[key(i, base_m[i] | 18'd1)] = data_m[i][31:16];
            end
            if (reset) begin
                busy_m[i] = 1'b0; k_m[i] = 0; exp_rd_m[i] = 32'h0; exp_addr_m[i] = 18'h0;
            end else if (!busy_m[i]) begin
                if (mem_r_en_s[i] || mem_w_en_s[i]) begin
                    busy_m[i] = 1'b1; k_m[i] = 1; wr_m[i] = mem_w_en_s[i];
                    base_m[i] = hw_base(alu_result_s[i]); data_m[i] = st_value_s[i];
                end
            end else begin
                if (k_m[i] == 2 * wc && !wr_m[i])
                    exp_rd_m[i] = {shadow_rd(key(i, base_m[i] | 18'd1)), shadow_rd(key(i, base_m[i]))};
                if (k_m[i] == 2 * wc + 1) begin
                    busy_m[i] = 1'b0; exp_addr_m[i] = base_m[i] | 18'd1;
                end else begin
                    k_m[i] = k_m[i] + 1;
                end
            end
        end
        if (reset) started = 1'b1;
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clock) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                int          wc;
                logic [17:0] e_addr;
                logic        e_rdy, e_wen;
                logic [15:0] e_dq;
                bit          do_rd, do_dq;
                wc = wait_m[i]; do_rd = 1'b1; do_dq = 1'b0; e_dq = 16'h0;
                if (!busy_m[i]) begin
                    e_rdy = ~(mem_r_en_s[i] | mem_w_en_s[i]); e_wen = 1'b1; e_addr = exp_addr_m[i];
                end else if (k_m[i] <= 2 * wc) begin
                    e_rdy  = 1'b0;
                    e_addr = (k_m[i] > wc) ? (base_m[i] | 18'd1) : base_m[i];
                    e_wen  = ~wr_m[i];
                    do_dq  = wr_m[i];
                    e_dq   = (k_m[i] > wc) ? data_m[i][31:16] : data_m[i][15:0];
                    do_rd  = (k_m[i] <= wc);
                end else begin
                    e_rdy = 1'b1; e_wen = 1'b1; e_addr = base_m[i] | 18'd1;
                end
                chk($sformatf("i%0d ready", i), {31'h0, ready_s[i]}, {31'h0, e_rdy});
                chk($sformatf("i%0d we_n", i), {31'h0, sram_we_n_s[i]}, {31'h0, e_wen});
                chk($sformatf("i%0d dq_oe", i), {31'h0, sram_dq_oe_s[i]}, {31'h0, ~e_wen});
                chk($sformatf("i%0d sram_addr", i), {14'h0, sram_addr_s[i]}, {14'h0, e_addr});
                if (do_dq) chk($sformatf("i%0d dq_out", i), {16'h0, sram_dq_out_s[i]}, {16'h0, e_dq});
                if (do_rd) chk($sformatf("i%0d read_data", i), read_data_s[i], exp_rd_m[i]);
            end
        end
    end

    // Issue one request on instance i and hold it until the DONE cycle.
    task automatic do_op(input int i, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] s, output int stall, output logic [31:0] rd,
                         output logic [17:0] lo_a, output logic [15:0] lo_d,
                         output logic [17:0] hi_a, output logic [15:0] hi_d);
        bit done;
        mem_r_en_s[i] = r; mem_w_en_s[i] = w; alu_result_s[i] = a; st_value_s[i] = s;
        stall = 0; done = 1'b0; rd = 32'h0;
        lo_a = 18'h0; lo_d = 16'h0; hi_a = 18'h0; hi_d = 16'h0;
        for (int j = 0; j < 40 && !done; j++) begin
            @(negedge clock);
            if (j == 1) begin lo_a = sram_addr_s[i]; lo_d = sram_dq_out_s[i]; end
            if (j == wait_m[i] + 1) begin hi_a = sram_addr_s[i]; hi_d = sram_dq_out_s[i]; end
            if (ready_s[i]) begin done = 1'b1; rd = read_data_s[i]; end
            else stall++;
        end
        if (!done) chk($sformatf("i%0d ready timeout", i), 32'd0, 32'd1);
        @(posedge clock); #1;
        mem_r_en_s[i] = 1'b0; mem_w_en_s[i] = 1'b0;
    endtask

    int          stall;
    logic [31:0] rd;
    logic [17:0] lo_a, hi_a;
    logic [15:0] lo_d, hi_d;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_r_en_s[i] = 1'b0; mem_w_en_s[i] = 1'b0; alu_result_s[i] = 32'h0; st_value_s[i] = 32'h0;
        end
        @(posedge clock); #1;
        @(negedge clock);
        chk("reset read_data", read_data_s[0], 32'h0);
        chk("reset sram_addr", {14'h0, sram_addr_s[0]}, 32'h0);
        chk("reset we_n", {31'h0, sram_we_n_s[0]}, 32'd1);
        chk("reset ready", {31'h0, ready_s[0]}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        do_op(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("store stall", stall, 32'd5);
        chk("store lo addr", {14'h0, lo_a}, 32'd2);
        chk("store lo data", {16'h0, lo_d}, 32'h0000BEEF);
        chk("store hi addr", {14'h0, hi_a}, 32'd3);
        chk("store hi data", {16'h0, hi_d}, 32'h0000DEAD);
        chk("store keeps read_data", rd, 32'h0);
        @(posedge clock); #1;

        do_op(0, 1'b1, 1'b0, 32'd1028, 32'h0, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("load stall", stall, 32'd5);
        chk("load data", rd, 32'hDEADBEEF);
        @(posedge clock); #1;

        do_op(0, 1'b1, 1'b1, 32'd1024, 32'h12345678, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("both-en lo data", {16'h0, lo_d}, 32'h00005678);
        chk("both-en keeps read_data", rd, 32'hDEADBEEF);

        do_op(0, 1'b1, 1'b0, 32'd1024, 32'h0, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("b2b load data", rd, 32'h12345678);
        do_op(0, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("b2b store stall", stall, 32'd5);
        chk("b2b store lo addr", {14'h0, lo_a}, 32'd4);
        do_op(0, 1'b1, 1'b0, 32'd1032, 32'h0, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("b2b reload", rd, 32'hCAFEF00D);
        @(posedge clock); #1;

        do_op(0, 1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("wrap lo addr", {14'h0, lo_a}, 32'h0003FFFE);
        chk("wrap hi addr", {14'h0, hi_a}, 32'h0003FFFF);
        do_op(0, 1'b1, 1'b0, 32'd1020, 32'h0, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("wrap load", rd, 32'hA5A55A5A);
        @(posedge clock); #1;

        mem_w_en_s[0] = 1'b1; alu_result_s[0] = 32'd1040; st_value_s[0] = 32'h11223344;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1; mem_w_en_s[0] = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort we_n", {31'h0, sram_we_n_s[0]}, 32'd1);
        chk("abort dq_oe", {31'h0, sram_dq_oe_s[0]}, 32'd0);
        chk("abort ready", {31'h0, ready_s[0]}, 32'd1);
        chk("abort read_data", read_data_s[0], 32'h0);
        @(posedge clock); #1;

        do_op(1, 1'b0, 1'b1, 32'd1024, 32'h0BADCAFE, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("w1 store stall", stall, 32'd3);
        chk("w1 lo addr", {14'h0, lo_a}, 32'd0);
        chk("w1 hi addr", {14'h0, hi_a}, 32'd1);
        chk("w1 hi data", {16'h0, hi_d}, 32'h00000BAD);
        @(posedge clock); #1;
        do_op(1, 1'b1, 1'b0, 32'd1024, 32'h0, stall, rd, lo_a, lo_d, hi_a, hi_d);
        chk("w1 load stall", stall, 32'd3);
        chk("w1 load data", rd, 32'h0BADCAFE);

        repeat (3) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
